// File: rtl/corr_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | corr_pkg - shared constants and state encoding for the lag sequencer     |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
package corr_pkg;
  localparam int NLAG    = 64;
  localparam int LAG_W   = $clog2(NLAG);
  // One strobe cycle plus one shift-setup cycle on top of the lag burst
  localparam int MIN_DIV = NLAG + 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STROBE = 3'd3,
    ST_BURST  = 3'd4,
    ST_FEND   = 3'd5
  } state_t;
endpackage
`default_nettype wire

// File: rtl/corr_tick_div.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | corr_tick_div - free-running sample divider, tick on count == div-1      |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module corr_tick_div
  import corr_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == (div - DIV_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/corr_lag_sched.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | corr_lag_sched - sample strobe, lag burst tagging and frame sequencing   |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module corr_lag_sched
  import corr_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int FRM_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [FRM_W-1:0] cfg_frame,
  output logic             sin_o,
  output logic             lag_valid,
  output logic [LAG_W-1:0] lag_idx,
  output logic             acc_clr,
  output logic             frame_done,
  output logic             overrun,
  output logic             busy
);
  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_eff;
  logic [FRM_W-1:0] frame_lim, scnt, scnt_nxt;
  logic [LAG_W:0]   bcnt, bcnt_nxt;
  logic             stop_flag, tick, last_lag, cnt_en, cnt_clr, drop, lag_nxt;

  assign cnt_en   = (state == ST_WAIT) || (state == ST_STROBE) || (state == ST_BURST);
  assign cnt_clr  = (state == ST_CLR) || (state == ST_IDLE);
  assign last_lag = (state == ST_BURST) && (bcnt == (LAG_W+1)'(NLAG));
  // A tick on the final lag cycle chains straight into the next strobe
  assign drop     = tick && ((state == ST_STROBE) || ((state == ST_BURST) && !last_lag));
  assign lag_nxt  = (state_nxt == ST_BURST) && (bcnt_nxt != '0);

  corr_tick_div #(.DIV_W(DIV_W)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .div   (div_eff),
    .tick  (tick)
  );

  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    bcnt_nxt  = bcnt;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_CLR;
      ST_CLR: begin
        scnt_nxt  = '0;
        state_nxt = ST_WAIT;
      end
      ST_WAIT:   if (tick) state_nxt = ST_STROBE;
      ST_STROBE: begin
        scnt_nxt  = scnt + FRM_W'(1);
        bcnt_nxt  = '0;
        state_nxt = ST_BURST;
      end
      ST_BURST: begin
        if (!last_lag) begin
          bcnt_nxt = bcnt + (LAG_W+1)'(1);
        end else if (scnt == frame_lim) begin
          state_nxt = ST_FEND;
        end else if (tick) begin
          state_nxt = ST_STROBE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_FEND:   state_nxt = (stop_flag || stop) ? ST_IDLE : ST_CLR;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      scnt       <= '0;
      bcnt       <= '0;
      div_eff    <= '0;
      frame_lim  <= '0;
      stop_flag  <= 1'b0;
      overrun    <= 1'b0;
      sin_o      <= 1'b0;
      lag_valid  <= 1'b0;
      lag_idx    <= '0;
      acc_clr    <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
      bcnt  <= bcnt_nxt;
      if ((state == ST_IDLE) && start) begin
        div_eff   <= (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
        frame_lim <= (cfg_frame == '0) ? FRM_W'(1) : cfg_frame;
        overrun   <= 1'b0;
      end else if (drop) begin
        overrun <= 1'b1;
      end
      if (state == ST_IDLE) stop_flag <= 1'b0;
      else if (stop)        stop_flag <= 1'b1;
      sin_o      <= (state_nxt == ST_STROBE);
      lag_valid  <= lag_nxt;
      lag_idx    <= lag_nxt ? LAG_W'(bcnt_nxt - (LAG_W+1)'(1)) : '0;
      acc_clr    <= (state_nxt == ST_CLR);
      frame_done <= (state_nxt == ST_FEND);
      busy       <= (state_nxt != ST_IDLE);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_corr_lag_sched.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_corr_lag_sched - randomized bench against an event-timeline model     |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module tb_corr_lag_sched;
  import corr_pkg::*;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst_n, start, stop;
  logic [15:0] cfg_div;
  logic [23:0] cfg_frame;
  logic        sin_o, lag_valid, acc_clr, frame_done, overrun, busy;
  logic [5:0]  lag_idx;

  int tests = 0;
  int fails = 0;

  // Expected output timeline, indexed by clock count after the start edge
  bit e_sin[MAXC], e_lv[MAXC], e_clr[MAXC], e_fd[MAXC], e_busy[MAXC];
  int e_idx[MAXC];

  corr_lag_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_div(cfg_div), .cfg_frame(cfg_frame),
    .sin_o(sin_o), .lag_valid(lag_valid), .lag_idx(lag_idx),
    .acc_clr(acc_clr), .frame_done(frame_done), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame c starts with acc_clr at c; sample k strobes at c+1+k*div; lags follow
  // two cycles later; frame_done lands NLAG+2 after the last strobe.
  task automatic build_model(input int dv, input int fr, input int stop_at, output int last);
    int de, fe, c, st;
    for (int i = 0; i < MAXC; i++) begin
      e_sin[i] = 0; e_lv[i] = 0; e_clr[i] = 0; e_fd[i] = 0; e_busy[i] = 0; e_idx[i] = 0;
    end
    de = (dv < NLAG + 2) ? NLAG + 2 : dv;
    fe = (fr == 0) ? 1 : fr;
    c = 1;
    last = 0;
    while (c + 2 + fe * de + NLAG < MAXC) begin
      e_clr[c] = 1;
      st = c;
      for (int k = 1; k <= fe; k++) begin
        st = c + 1 + k * de;
        e_sin[st] = 1;
        for (int j = 0; j < NLAG; j++) begin
          e_lv[st + 2 + j]  = 1;
          e_idx[st + 2 + j] = j;
        end
      end
      last = st + NLAG + 2;
      e_fd[last] = 1;
      for (int i = c; i <= last; i++) e_busy[i] = 1;
      if (stop_at <= last) break;
      c = last + 1;
    end
  endtask

  function automatic logic [11:0] exp_vec(int i);
    return {e_sin[i], e_lv[i], 6'(e_idx[i]), e_clr[i], e_fd[i], 1'b0, e_busy[i]};
  endfunction

  function automatic logic [11:0] act_vec(int i);
    return {sin_o, lag_valid, (e_lv[i] ? lag_idx : 6'd0), acc_clr, frame_done, overrun, busy};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_div = 16'd100; cfg_frame = 24'd3;
    #2;
    tests++;
    if ({sin_o, lag_valid, lag_idx, acc_clr, frame_done, overrun, busy} !== 12'd0) begin
      fails++;
      $display("FAIL reset_hold: got %b want 0", {sin_o, lag_valid, lag_idx, acc_clr, frame_done, overrun, busy});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stop = 1'b1;
    repeat (3) @(posedge clk);
    #1 stop = 1'b0;
    tests++;
    if ({sin_o, lag_valid, acc_clr, frame_done, overrun, busy} !== 6'd0) begin
      fails++;
      $display("FAIL idle_after_reset: got %b want 0", {sin_o, lag_valid, acc_clr, frame_done, overrun, busy});
    end
  endtask

  task automatic test_frame_schedule();
    int tdiv[3]  = '{100, 10, 100};
    int tfr[3]   = '{3, 2, 3};
    int tstop[3] = '{400, 5, 230};
    int last;
    for (int t = 0; t < 3; t++) begin
      do_reset();
      cfg_div = 16'(tdiv[t]); cfg_frame = 24'(tfr[t]);
      build_model(tdiv[t], tfr[t], tstop[t], last);
      for (int i = 0; i < last + 10; i++) begin
        start = (i == 0); stop = (i == tstop[t]);
        @(posedge clk); #1;
        tests++;
        if (act_vec(i + 1) !== exp_vec(i + 1)) begin
          fails++;
          $display("FAIL schedule[%0d] cyc %0d: got %b want %b", t, i + 1, act_vec(i + 1), exp_vec(i + 1));
        end
      end
      start = 1'b0; stop = 1'b0;
    end
  endtask

  task automatic test_shift_align();
    logic [7:0] samp[16];
    logic [7:0] ram[64];
    logic [7:0] hist[$];
    logic [7:0] got, want;
    int dv, last, wp, nd, nm;
    do_reset();
    dv = $urandom_range(66, 120);
    cfg_div = 16'(dv); cfg_frame = 24'd4;
    build_model(dv, 4, 3, last);
    for (int k = 0; k < 16; k++) samp[k] = 8'($urandom);
    for (int k = 0; k < 64; k++) begin ram[k] = 8'd0; hist.push_back(8'd0); end
    wp = 0; nd = 0; nm = 0;
    for (int i = 0; i < last + 10; i++) begin
      start = (i == 0); stop = (i == 3);
      @(posedge clk); #1;
      if (e_sin[i + 1]) begin hist.push_front(samp[nm % 16]); nm++; end
      if (sin_o) begin ram[wp] = samp[nd % 16]; wp = (wp + 1) % 64; nd++; end
      tests++;
      if (act_vec(i + 1) !== exp_vec(i + 1)) begin
        fails++;
        $display("FAIL align_ctl cyc %0d: got %b want %b", i + 1, act_vec(i + 1), exp_vec(i + 1));
      end
      if (e_lv[i + 1]) begin
        got  = ram[(wp - 1 - int'(lag_idx)) & 63];
        want = hist[e_idx[i + 1]];
        tests++;
        if (got !== want) begin
          fails++;
          $display("FAIL align_data cyc %0d: got %h want %h", i + 1, got, want);
        end
      end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_busy_ignore();
    int last;
    do_reset();
    cfg_div = 16'd70; cfg_frame = 24'd2;
    build_model(70, 2, 50, last);
    for (int i = 0; i < last + 10; i++) begin
      start = (i == 0) || (e_busy[i] && ($urandom_range(0, 7) == 0));
      stop  = (i == 50);
      @(posedge clk); #1;
      cfg_div = 16'($urandom); cfg_frame = 24'($urandom_range(0, 9));
      tests++;
      if (act_vec(i + 1) !== exp_vec(i + 1)) begin
        fails++;
        $display("FAIL busy_ignore cyc %0d: got %b want %b", i + 1, act_vec(i + 1), exp_vec(i + 1));
      end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int last, at;
    at = -1;
    do_reset();
    cfg_div = 16'd100; cfg_frame = 24'd3;
    for (int i = 0; i < 400 && at < 0; i++) begin
      start = (i == 0);
      @(posedge clk); #1;
      if (lag_valid && lag_idx == 6'd30) at = i + 1;
    end
    start = 1'b0;
    tests++;
    if (at != 134) begin
      fails++;
      $display("FAIL lag30_cycle: got %0d want 134", at);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({sin_o, lag_valid, lag_idx, acc_clr, frame_done, overrun, busy} !== 12'd0) begin
      fails++;
      $display("FAIL async_reset: got %b want 0", {sin_o, lag_valid, lag_idx, acc_clr, frame_done, overrun, busy});
    end
    #2 rst_n = 1'b1;
    build_model(100, 3, 10, last);
    for (int i = 0; i < last + 10; i++) begin
      start = (i == 0); stop = (i == 10);
      @(posedge clk); #1;
      tests++;
      if (act_vec(i + 1) !== exp_vec(i + 1)) begin
        fails++;
        $display("FAIL restart cyc %0d: got %b want %b", i + 1, act_vec(i + 1), exp_vec(i + 1));
      end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_random();
    int dv, fr, sa, last;
    for (int t = 0; t < 4; t++) begin
      do_reset();
      dv = $urandom_range(0, 150);
      fr = $urandom_range(0, 3);
      build_model(dv, fr, 1, last);
      sa = $urandom_range(1, last);
      build_model(dv, fr, sa, last);
      cfg_div = 16'(dv); cfg_frame = 24'(fr);
      for (int i = 0; i < last + 10; i++) begin
        start = (i == 0); stop = (i == sa);
        @(posedge clk); #1;
        tests++;
        if (act_vec(i + 1) !== exp_vec(i + 1)) begin
          fails++;
          $display("FAIL random[%0d] div=%0d frm=%0d cyc %0d: got %b want %b",
                   t, dv, fr, i + 1, act_vec(i + 1), exp_vec(i + 1));
        end
      end
      start = 1'b0; stop = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_frame_schedule();
    test_shift_align();
    test_busy_ignore();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
